// File: rtl/fifo_stream_reader_if.sv
// Bundle of the FIFO read port, the output stream and the flush/status
// signals of the fifo_stream_reader. The master is the reader itself. The
// slave is the surrounding logic: the FIFO instance, the consumer and the
// controller.
interface fifo_stream_reader_if #(
  parameter int DataWidth  = 64,
  parameter int CountWidth = 32
) ();
  logic                  fifo_empty;
  logic [DataWidth-1:0]  fifo_rd_data;
  logic                  fifo_rd_en;
  logic                  out_valid;
  logic [DataWidth-1:0]  out_data;
  logic                  out_ready;
  logic                  flush;
  logic                  flush_busy;
  logic                  flush_done;
  logic [CountWidth-1:0] beat_count;

  modport master (
    input  fifo_empty, fifo_rd_data, out_ready, flush,
    output fifo_rd_en, out_valid, out_data, flush_busy, flush_done, beat_count
  );

  modport slave (
    output fifo_empty, fifo_rd_data, out_ready, flush,
    input  fifo_rd_en, out_valid, out_data, flush_busy, flush_done, beat_count
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side master for a show-ahead FIFO. It drains FIFO words into a
// valid/ready stream through a 2-entry skid buffer (slot0 = output register,
// slot1 = skid register). The pop request depends only on registered
// occupancy, the FIFO empty flag and flush, so out_ready never reaches
// fifo_rd_en combinationally. A flush discards the buffered words and pops
// the FIFO until it is seen empty.

// Invariant checker for the reader's internal state and handshake outputs.
module fifo_stream_reader_checker (
  input logic       clk,
  input logic       rst,
  input logic [1:0] occ,
  input logic       out_valid,
  input logic       fifo_rd_en,
  input logic       fifo_empty,
  input logic       flush_busy,
  input logic       flush_done
);
  a_occ_range: assert property (@(posedge clk) disable iff (rst) occ <= 2'd2)
    else $error("occupancy out of range");
  a_valid_occ: assert property (@(posedge clk) disable iff (rst) out_valid == (occ != 2'd0))
    else $error("out_valid does not track occupancy");
  a_no_empty_pop: assert property (@(posedge clk) !(fifo_rd_en && fifo_empty))
    else $error("pop issued while FIFO empty");
  a_busy_novalid: assert property (@(posedge clk) disable iff (rst) !(flush_busy && out_valid))
    else $error("out_valid during flush");
  a_done_notbusy: assert property (@(posedge clk) disable iff (rst) flush_done |-> !flush_busy)
    else $error("flush_done while busy");
endmodule

module fifo_stream_reader #(
  parameter int DataWidth  = 64,
  parameter int CountWidth = 32
) (
  input logic                 clk,
  input logic                 rst,
  fifo_stream_reader_if.master bus
);

  typedef enum logic [0:0] {
    ST_STREAM = 1'b0,
    ST_FLUSH  = 1'b1
  } state_t;

  state_t                state_r;
  logic [1:0]            occ_r;
  logic [DataWidth-1:0]  slot0_r;
  logic [DataWidth-1:0]  slot1_r;
  logic [CountWidth-1:0] beat_count_r;
  logic                  flush_busy_r;
  logic                  flush_done_r;

  logic                  pop_s;
  logic                  accept_s;
  logic                  drain_s;

  // Pop/accept decisions. A flush request suppresses both in the cycle it is
  // sampled. While flushing, the FIFO is popped whenever it has data.
  always_comb begin
    pop_s    = 1'b0;
    accept_s = 1'b0;
    drain_s  = 1'b0;
    if (rst) begin
      pop_s    = 1'b0;
      accept_s = 1'b0;
      drain_s  = 1'b0;
    end else begin
      case (state_r)
        ST_STREAM: begin
          pop_s    = !bus.fifo_empty && (occ_r < 2'd2) && !bus.flush;
          accept_s = (occ_r != 2'd0) && bus.out_ready && !bus.flush;
        end
        ST_FLUSH: begin
          drain_s = !bus.fifo_empty;
        end
        default: begin
          pop_s    = 1'b0;
          accept_s = 1'b0;
          drain_s  = 1'b0;
        end
      endcase
    end
  end

  assign bus.fifo_rd_en = pop_s | drain_s;
  assign bus.out_valid  = (occ_r != 2'd0);
  assign bus.out_data   = slot0_r;
  assign bus.flush_busy = flush_busy_r;
  assign bus.flush_done = flush_done_r;
  assign bus.beat_count = beat_count_r;

  // Stream/flush state machine with the skid buffer, the beat counter and the
  // flush status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_STREAM;
      occ_r        <= 2'd0;
      beat_count_r <= {CountWidth{1'b0}};
      flush_busy_r <= 1'b0;
      flush_done_r <= 1'b0;
    end else begin
      case (state_r)
        ST_STREAM: begin
          flush_done_r <= 1'b0;
          if (bus.flush) begin
            occ_r        <= 2'd0;
            state_r      <= ST_FLUSH;
            flush_busy_r <= 1'b1;
          end else begin
            if (accept_s) begin
              beat_count_r <= beat_count_r + CountWidth'(1);
            end
            case (occ_r)
              2'd0: begin
                if (pop_s) begin
                  slot0_r <= bus.fifo_rd_data;
                  occ_r   <= 2'd1;
                end
              end
              2'd1: begin
                if (pop_s && accept_s) begin
                  slot0_r <= bus.fifo_rd_data;
                end else if (pop_s) begin
                  slot1_r <= bus.fifo_rd_data;
                  occ_r   <= 2'd2;
                end else if (accept_s) begin
                  occ_r <= 2'd0;
                end
              end
              2'd2: begin
                if (accept_s) begin
                  slot0_r <= slot1_r;
                  occ_r   <= 2'd1;
                end
              end
              default: begin
                occ_r <= 2'd0;
              end
            endcase
          end
        end
        ST_FLUSH: begin
          occ_r <= 2'd0;
          if (bus.fifo_empty) begin
            state_r      <= ST_STREAM;
            flush_busy_r <= 1'b0;
            flush_done_r <= 1'b1;
          end else begin
            flush_done_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= ST_STREAM;
          occ_r        <= 2'd0;
          flush_busy_r <= 1'b0;
          flush_done_r <= 1'b0;
        end
      endcase
    end
  end

  fifo_stream_reader_checker u_checker (
    .clk        (clk),
    .rst        (rst),
    .occ        (occ_r),
    .out_valid  (bus.out_valid),
    .fifo_rd_en (bus.fifo_rd_en),
    .fifo_empty (bus.fifo_empty),
    .flush_busy (flush_busy_r),
    .flush_done (flush_done_r)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader. A small show-ahead FIFO model feeds the DUT.
// Every word written to the FIFO is queued as an expected beat. A monitor
// checks each accepted beat against the queue. A per-cycle vector table
// covers drain, backpressure and empty behaviour. Hand-written sequences
// cover flush, reset mid-stream and counter wrap. CountWidth is 4 so that the
// counter wraps.
module tb_fifo_stream_reader;

  localparam int DW = 64;
  localparam int CW = 4;

  logic clk;
  logic rst;

  fifo_stream_reader_if #(.DataWidth(DW), .CountWidth(CW)) bus ();

  fifo_stream_reader #(.DataWidth(DW), .CountWidth(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Show-ahead FIFO model.
  logic [DW-1:0] mem [0:63];
  bit   [6:0]    wr_ptr = 7'd0;
  bit   [6:0]    rd_ptr = 7'd0;

  assign bus.fifo_empty   = (rd_ptr == wr_ptr);
  assign bus.fifo_rd_data = mem[rd_ptr[5:0]];

  always @(posedge clk) begin
    if (bus.fifo_rd_en && (rd_ptr != wr_ptr)) rd_ptr <= rd_ptr + 7'd1;
  end

  logic [DW-1:0] sb [$];
  int n_checks = 0;
  int n_fail   = 0;
  int next_word = 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fifo_write(logic [DW-1:0] d);
    mem[wr_ptr[5:0]] = d;
    wr_ptr = wr_ptr + 7'd1;
    sb.push_back(d);
  endtask

  task automatic push_word();
    logic [DW-1:0] d;
    d = 64'(next_word) * 64'h11;
    next_word++;
    fifo_write(d);
  endtask

  // Accepted-beat monitor and per-cycle invariants.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    check("no_pop_when_empty", {63'd0, bus.fifo_rd_en && bus.fifo_empty}, 64'd0);
    if (!rst) begin
      check("no_valid_in_flush", {63'd0, bus.flush_busy && bus.out_valid}, 64'd0);
      if (bus.out_valid && bus.out_ready && !bus.flush) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", bus.out_data, 64'hdead);
        end else begin
          e = sb.pop_front();
          check("beat_data", bus.out_data, e);
        end
      end
    end
  end

  typedef struct {
    int          npush;
    logic        ready;
    logic        fl;
    logic        e_rd_en;
    logic        e_valid;
    logic [63:0] e_data;
    logic [3:0]  e_count;
  } vec_t;

  vec_t tbl [$];

  task automatic add(int n, logic r, logic f, logic ren, logic v, logic [63:0] d, logic [3:0] c);
    vec_t x;
    x.npush = n; x.ready = r; x.fl = f; x.e_rd_en = ren;
    x.e_valid = v; x.e_data = d; x.e_count = c;
    tbl.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(string name);
    int i;
    for (i = 0; i < 200 && (sb.size() != 0 || bus.out_valid); i++) @(negedge clk);
    check(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int disc;
    bit found;
    rst = 1'b1;
    bus.out_ready = 1'b0;
    bus.flush = 1'b0;

    // Drain, backpressure and empty-safety vectors.
    add(3, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0,  4'd0);
    add(0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h11, 4'd0);
    add(0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h22, 4'd1);
    add(0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h33, 4'd2);
    add(0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,  4'd3);
    add(4, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0,  4'd3);
    add(0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h44, 4'd3);
    add(0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h44, 4'd3);
    add(0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h44, 4'd3);
    add(0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h44, 4'd3);
    add(0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h44, 4'd3);
    add(0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h55, 4'd4);
    add(0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h66, 4'd5);
    add(0, 1'b1, 1'b0, 1'b0, 1'b1, 64'h77, 4'd6);
    add(0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,  4'd7);
    for (int i = 0; i < 20; i++) add(0, 1'(i % 2), 1'b0, 1'b0, 1'b0, 64'h0, 4'd7);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", {63'd0, bus.fifo_rd_en}, 64'd0);
    check("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_busy",  {63'd0, bus.flush_busy}, 64'd0);
    check("rst_done",  {63'd0, bus.flush_done}, 64'd0);
    check("rst_count", 64'(bus.beat_count), 64'd0);
    step();
    rst = 1'b0;

    foreach (tbl[i]) begin
      step();
      repeat (tbl[i].npush) push_word();
      bus.out_ready = tbl[i].ready;
      bus.flush = tbl[i].fl;
      @(negedge clk);
      check($sformatf("row%0d_rd_en", i), {63'd0, bus.fifo_rd_en}, {63'd0, tbl[i].e_rd_en});
      check($sformatf("row%0d_valid", i), {63'd0, bus.out_valid}, {63'd0, tbl[i].e_valid});
      if (tbl[i].e_valid) check($sformatf("row%0d_data", i), bus.out_data, tbl[i].e_data);
      check($sformatf("row%0d_count", i), 64'(bus.beat_count), 64'(tbl[i].e_count));
      check($sformatf("row%0d_busy", i), {63'd0, bus.flush_busy}, 64'd0);
    end

    // Flush with occ=2 and 5 words left in the FIFO.
    step();
    repeat (7) push_word();
    bus.out_ready = 1'b0;
    step();
    step();
    @(negedge clk);
    check("fl_pre_valid", {63'd0, bus.out_valid}, 64'd1);
    check("fl_pre_data", bus.out_data, 64'h88);
    check("fl_pre_rd_en", {63'd0, bus.fifo_rd_en}, 64'd0);
    step();
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    sb.delete();
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    check("fl_valid", {63'd0, bus.out_valid}, 64'd0);
    check("fl_busy", {63'd0, bus.flush_busy}, 64'd1);
    check("fl_count", 64'(bus.beat_count), 64'd7);
    disc = 0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (bus.fifo_rd_en) disc++;
      if (bus.flush_done) found = 1'b1;
      else @(negedge clk);
    end
    check("fl_done_seen", {63'd0, found}, 64'd1);
    check("fl_discards", 64'(disc), 64'd5);
    check("fl_done_busy", {63'd0, bus.flush_busy}, 64'd0);
    check("fl_post_count", 64'(bus.beat_count), 64'd7);
    @(negedge clk);
    check("fl_done_pulse", {63'd0, bus.flush_done}, 64'd0);
    step();
    fifo_write(64'hAA);
    wait_drain("fl_new_word_drain");
    check("fl_new_count", 64'(bus.beat_count), 64'd8);

    // Reset mid-stream with occ=2 and out_ready=0.
    step();
    repeat (4) push_word();
    bus.out_ready = 1'b0;
    step();
    step();
    @(negedge clk);
    check("mr_pre_valid", {63'd0, bus.out_valid}, 64'd1);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("mr_rd_en", {63'd0, bus.fifo_rd_en}, 64'd0);
    check("mr_valid", {63'd0, bus.out_valid}, 64'd0);
    check("mr_count", 64'(bus.beat_count), 64'd0);
    check("mr_done", {63'd0, bus.flush_done}, 64'd0);
    void'(sb.pop_front());
    void'(sb.pop_front());
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("mr_resume_rd_en", {63'd0, bus.fifo_rd_en}, 64'd1);
    wait_drain("mr_drain");
    check("mr_post_count", 64'(bus.beat_count), 64'd2);

    // Counter wrap: 17 beats from zero with a 4-bit counter.
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (17) push_word();
    wait_drain("wrap_drain");
    check("wrap_count", 64'(bus.beat_count), 64'd1);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
